// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation codes, FSM state encoding, iteration count and a sign helper.
package muldiv_pkg;

   localparam int ITER_DEFAULT = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MFHI  = 3'd6;
   localparam logic [2:0] OP_MFLO  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FIXUP = 2'd2
   } state_t;

   // Magnitude of a two's-complement value when en is set, else pass through.
   function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
      return (en && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// acc holds {HI,LO}: for multiply LO starts as the multiplier and the product
// shifts in from the top; for divide HI is the partial remainder and LO the
// dividend, with quotient bits shifting in at the bottom.
module muldiv_step (
   input  logic        is_div_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] b_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [31:0] diff;
   logic        fits;

   // Single combinational step for both operations
   always_comb begin
      sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_i} : 33'd0);
      // Shifted remainder is acc_i[63:31]; it is always < 2*b, so the low
      // 32 bits of the difference are the new remainder when it fits.
      fits = (acc_i[63:31] >= {1'b0, b_i});
      diff = acc_i[62:31] - b_i;
      if (is_div_i) begin
         acc_o = fits ? {diff, acc_i[30:0], 1'b1} : {acc_i[62:0], 1'b0};
      end else begin
         acc_o = {sum, acc_i[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit: magnitudes are processed for ITER
// cycles, then a single fixup cycle restores signs and writes HI/LO.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] b_q;
   logic        is_div_q;
   logic        neg_lo_q;   // product sign (multiply) or quotient sign (divide)
   logic        neg_hi_q;   // remainder sign (divide only)
   logic        div0_q;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic [63:0] acc_step;
   logic        sgn_op;
   logic [31:0] rs_abs;
   logic [31:0] rt_abs;
   logic [63:0] prod_neg;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   muldiv_step u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .b_i      (b_q),
      .acc_o    (acc_step)
   );

   // Operand conditioning and sign correction of the finished result
   always_comb begin
      sgn_op   = (op == OP_MULT) || (op == OP_DIV);
      rs_abs   = abs_if(rs_val, sgn_op);
      rt_abs   = abs_if(rt_val, sgn_op);
      prod_neg = ~acc_q + 64'd1;
      if (is_div_q) begin
         fix_hi = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
         // Divide by zero: quotient is all ones; the remainder path above
         // already reproduces the original dividend.
         fix_lo = div0_q ? 32'hFFFF_FFFF
                         : (neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
      end else begin
         fix_hi = neg_lo_q ? prod_neg[63:32] : acc_q[63:32];
         fix_lo = neg_lo_q ? prod_neg[31:0]  : acc_q[31:0];
      end
   end

   // Control FSM, iteration counter and HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         acc_q    <= 64'd0;
         b_q      <= 32'd0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         busy_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !flush) begin
                  if (!op[2]) begin
                     acc_q    <= {32'd0, rs_abs};
                     b_q      <= rt_abs;
                     is_div_q <= op[1];
                     neg_lo_q <= sgn_op & (rs_val[31] ^ rt_val[31]);
                     neg_hi_q <= sgn_op & op[1] & rs_val[31];
                     div0_q   <= op[1] & (rt_val == 32'd0);
                     cnt_q    <= 6'd0;
                     busy_q   <= 1'b1;
                     state_q  <= ST_BUSY;
                  end else if (op == OP_MTHI) begin
                     hi_q <= rs_val;
                  end else if (op == OP_MTLO) begin
                     lo_q <= rs_val;
                  end
               end
            end
            ST_BUSY: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= acc_step;
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_FIXUP;
                  end
               end
            end
            ST_FIXUP: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
               if (!flush) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // busy_q covers both BUSY and FIXUP, so it alone decides stalling
   assign stall  = start & busy_q & ~reset;
   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with a result scoreboard.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        busy;
   logic        stall;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb_q[$];
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   muldiv_seq #(.ITER(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s value=%h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference {HI,LO} for arithmetic ops
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] p;
      int signed q;
      int signed r;
      case (o)
         3'd0: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return p;
         end
         3'd1: return {32'd0, a} * {32'd0, b};
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
      endcase
   endfunction

   // Issue an arithmetic op, wait (bounded) for completion, score the result
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      int n;
      logic [63:0] exp;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      sb_q.push_back(model(o, a, b));
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
      exp = sb_q.pop_front();
      chk({tag, "_hilo"}, {hi_out, lo_out}, exp);
      hi_m = exp[63:32];
      lo_m = exp[31:0];
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      op     = 3'd0;
      rs_val = 32'd0;
      rt_val = 32'd0;
      flush  = 1'b0;
      tick();
      tick();
      chk("reset_stall", {63'd0, stall}, 64'd0);
      reset = 1'b0;
      tick();
      chk("reset_state", {30'd0, busy, stall, hi_out, lo_out}, 64'd0);

      // Directed arithmetic cases
      run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
      run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
      run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
      run_op("divu_by0", 3'd3, 32'h1234_5678, 32'd0);
      run_op("div_by0_neg", 3'd2, 32'h8765_4321, 32'd0);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Random arithmetic
      for (int i = 0; i < 6; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         logic [31:0] rb;
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      end

      // MTHI, then MULTU flushed in cycle 10
      start = 1'b1; op = 3'd4; rs_val = 32'hAAAA_5555;
      tick();
      start = 1'b0;
      hi_m = 32'hAAAA_5555;
      chk("mthi", {32'd0, hi_out}, {32'd0, hi_m});
      start = 1'b1; op = 3'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_hilo", {hi_out, lo_out}, {hi_m, lo_m});

      // Flush with MTLO in IDLE: MTLO ignored
      start = 1'b1; op = 3'd5; rs_val = 32'h1357_9BDF; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      chk("flush_mtlo", {32'd0, lo_out}, {32'd0, lo_m});

      // Flush during FIXUP (cycle 33): no HI/LO write
      start = 1'b1; op = 3'd3; rs_val = 32'd55; rt_val = 32'd4;
      tick();
      start = 1'b0;
      for (int c = 1; c < 33; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fixup_flush_busy", {63'd0, busy}, 64'd0);
      chk("fixup_flush_hilo", {hi_out, lo_out}, {hi_m, lo_m});

      // MFLO requested in cycle 5 of a DIVU stalls until cycle 34
      start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
      tick();
      start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      start = 1'b1; op = 3'd7;
      #1;
      begin
         int stall_n;
         stall_n = 0;
         for (int c = 5; c < 34; c++) begin
            if (stall) stall_n++;
            tick();
         end
         chk("mflo_stall_cycles", 64'(stall_n), 64'd29);
      end
      chk("mflo_stall_end", {63'd0, stall}, 64'd0);
      chk("mflo_lo", {hi_out, lo_out}, {32'd1, 32'd333});
      start = 1'b0;
      hi_m = 32'd1; lo_m = 32'd333;

      // Reset in cycle 20 of a MULT
      start = 1'b1; op = 3'd0; rs_val = 32'd12345; rt_val = 32'hFFFF_0001;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      reset = 1'b1; start = 1'b1; op = 3'd6;
      #1;
      chk("reset_mid_stall", {63'd0, stall}, 64'd0);
      tick();
      reset = 1'b0; start = 1'b0;
      chk("reset_mid_state", {31'd0, busy, hi_out, lo_out}, 64'd0);

      // Recovery after reset
      run_op("post_reset_mult", 3'd0, 32'd40000, 32'hFFFF_FFFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
